// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand/op upstream, result/zero/count downstream.
// master drives operands and out_ready; slave is the logic unit itself.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ops_done
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, ops_done
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined 8-function bitwise logic unit with valid/ready on both sides, zero flag and
// saturating completion counter. Define LU_INPUT_STAGE_EN to add an input register stage (latency 2).
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  logic_unit_pipe_if.slave lu
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  function automatic logic [WIDTH-1:0] lu_eval(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] opa,
    input logic [WIDTH-1:0] opb
  );
    logic [WIDTH-1:0] r;
    r = opa;
    case (sel)
      OP_NOT:  r = ~opa;
      OP_AND:  r = opa & opb;
      OP_OR:   r = opa | opb;
      OP_XOR:  r = opa ^ opb;
      OP_NAND: r = ~(opa & opb);
      OP_NOR:  r = ~(opa | opb);
      OP_XNOR: r = ~(opa ^ opb);
      OP_PASS: r = opa;
      default: r = opa;
    endcase
    return r;
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [CNT_W-1:0] ops_done_q;

  logic             out_adv;
  logic             xfer;
  logic             accept;
  logic             load_out;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] next_result;

  // Output register may take new data when empty or being drained this cycle.
  assign out_adv = !out_valid_q || lu.out_ready;
  assign xfer    = out_valid_q && lu.out_ready;
  assign accept  = lu.in_valid && lu.in_ready;

`ifdef LU_INPUT_STAGE_EN
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  assign lu.in_ready = !s1_valid || out_adv;
  assign load_out    = s1_valid && out_adv;
  assign src_op      = s1_op;
  assign src_a       = s1_a;
  assign src_b       = s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= lu.op;
      s1_a     <= lu.a;
      s1_b     <= lu.b;
    end else if (load_out) begin
      s1_valid <= 1'b0;
    end
  end
`else
  assign lu.in_ready = out_adv;
  assign load_out    = accept;
  assign src_op      = lu.op;
  assign src_a       = lu.a;
  assign src_b       = lu.b;
`endif

  assign next_result = lu_eval(src_op, src_a, src_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      result_q    <= next_result;
      zero_q      <= (next_result == '0);
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_q <= '0;
    end else if (xfer && (ops_done_q != CNT_MAX)) begin
      ops_done_q <= ops_done_q + 1'b1;
    end
  end

  assign lu.out_valid = out_valid_q;
  assign lu.result    = result_q;
  assign lu.zero      = zero_q;
  assign lu.ops_done  = ops_done_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: stimulus pushes expected results, a monitor pops on transfer.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  localparam int LAT =
`ifdef LU_INPUT_STAGE_EN
    2;
`else
    1;
`endif

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  logic_unit_pipe_if #(.WIDTH(32), .CNT_W(16)) bus ();
  logic_unit_pipe_if #(.WIDTH(8),  .CNT_W(3))  sbus ();

  logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .lu  (bus)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .lu  (sbus)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          vis;
    bit          strict;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] er, input bit strict);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    e.res    = er;
    e.z      = (er == 32'h0);
    e.vis    = cyc + LAT;
    e.strict = strict;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(bus.result), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(bus.result), 64'(e.res));
        chk("zero", 64'(bus.zero), 64'(e.z));
        if (e.strict) chk("latency", 64'(cyc), 64'(e.vis));
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;  bus.op = 3'd0;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.op = 3'd0; sbus.a = '0; sbus.b = '0; sbus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_zero",      64'(bus.zero),      64'd1);
    chk("rst_ops_done",  64'(bus.ops_done),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    bus.in_valid = 1'b1;
    bus.a = 32'h5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ignores_in_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // NOT sweep, first accept on the first edge after release
    send(3'd0, 32'd0,  32'h0, 32'hFFFF_FFFF, 1'b1);
    send(3'd0, 32'd10, 32'h0, 32'hFFFF_FFF5, 1'b1);
    send(3'd0, 32'd32, 32'h0, 32'hFFFF_FFDF, 1'b1);
    send(3'd0, 32'd33, 32'h0, 32'hFFFF_FFDE, 1'b1);
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #1;
    chk("not_sweep_ops_done", 64'(bus.ops_done), 64'd4);
    chk("not_sweep_idle", 64'(bus.out_valid), 64'd0);
    @(negedge clk);

    // all eight ops, back to back
    send(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1);
    send(3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1);
    send(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b1);
    send(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    send(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b1);
    send(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b1);
    send(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F, 1'b1);
    send(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b1);
    send(3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b1);
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #1;
    chk("all_ops_ops_done", 64'(bus.ops_done), 64'd13);
    @(negedge clk);

    // backpressure: one result held for five cycles
    bus.out_ready = 1'b0;
    send(3'd2, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0);
    bus.in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.a  = $urandom;
      bus.b  = $urandom;
      bus.op = 3'($urandom_range(0, 7));
      #1;
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_result",    64'(bus.result),    64'h1234_5678);
      chk("stall_in_ready",  64'(bus.in_ready),  (LAT == 1) ? 64'd0 : 64'd1);
      chk("stall_ops_done",  64'(bus.ops_done),  64'd13);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send(3'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    #1;
    chk("drain_accept_ops_done",  64'(bus.ops_done),  64'd14);
    chk("drain_accept_out_valid", 64'(bus.out_valid), (LAT == 1) ? 64'd1 : 64'd0);
    chk("drain_accept_result",    64'(bus.result),
        (LAT == 1) ? 64'hF0F0_0F0F : 64'h1234_5678);
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #1;
    chk("bp_final_ops_done", 64'(bus.ops_done), 64'd15);
    @(negedge clk);

    // asynchronous reset in the middle of a stall
    bus.out_ready = 1'b0;
    send(3'd7, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_reset_stalled", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_result",    64'(bus.result),    64'd0);
    chk("midrst_zero",      64'(bus.zero),      64'd1);
    chk("midrst_ops_done",  64'(bus.ops_done),  64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    #1;
    chk("post_rst_ops_done", 64'(bus.ops_done), 64'd1);
    @(negedge clk);

    // saturation on a 3-bit counter, 8-bit datapath, PASS op
    sbus.in_valid = 1'b1;
    sbus.op = 3'd7;
    for (int i = 0; i < 10; i++) begin
      sbus.a = 8'(i + 1);
      @(posedge clk);
      #1;
      if (i == 5) chk("sat_mid_ops_done", 64'(sbus.ops_done), 64'(6 - LAT));
    end
    sbus.in_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("sat_ops_done", 64'(sbus.ops_done), 64'd7);
    chk("sat_last_result", 64'(sbus.result), 64'd10);
    chk("sat_idle", 64'(sbus.out_valid), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the KGP-RISC ALU datapath; supersedes the fixed 32-bit single-function inverter.
- Performs one of eight bitwise operations on two WIDTH-bit operands.
- Uses a valid/ready handshake on both sides, a registered output stage with backpressure, a result zero flag and a saturating completed-operation counter for the core's performance counters.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 1..64.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept a transfer this cycle
- op  in  3  operation select, sampled on accept
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; ignored for NOT and PASS
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts the result
- result  out  WIDTH  registered result
- zero  out  1  high when result == 0; registered alongside result
- ops_done  out  CNT_W  saturating count of results consumed downstream

Behaviour:
- Op encoding:
  - 0 NOT: ~a
  - 1 AND: a&b
  - 2 OR: a|b
  - 3 XOR: a^b
  - 4 NAND: ~(a&b)
  - 5 NOR: ~(a|b)
  - 6 XNOR: ~(a^b)
  - 7 PASS: a
- All operations are full-width bitwise; no carry or sign semantics.
- Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational. A new operation can be accepted in the same cycle the held result is drained, giving 1 result per cycle at full throughput.
- Latency is 1 cycle: a result accepted at edge N is visible on result/zero with out_valid=1 after edge N.
- Output register load:
  - On accept, result and zero load on the clock edge.
  - Otherwise result and zero hold their value, including while out_valid=0.
- out_valid next state:
  - 1 on accept.
  - 0 on an output transfer with no accept.
  - Unchanged otherwise.
- Stall: while out_valid=1 and out_ready=0, result/zero/out_valid stay stable and in_ready=0. Input changes have no effect.
- ops_done increments by 1 on each output transfer and saturates at all-ones (no wrap).
- Reset (asynchronous, any time, including mid-stall) forces out_valid=0, result=0, zero=1, ops_done=0. In-flight data is discarded. in_ready is 1 while the unit is reset.
- An in_valid asserted during reset is ignored. The first accept is possible on the first rising edge after rst deasserts.
- Simultaneous accept and output transfer in one cycle:
  - The old result is consumed and counted.
  - The new result loads.
  - out_valid stays 1.
- WIDTH=1 is supported. zero is then ~result[0].

Optional Feature:
- Macro: LU_INPUT_STAGE_EN.
- Defined:
  - An input register stage (a, b, op, valid) is inserted before the compute/output register. Latency becomes 2 cycles.
  - Backpressure propagates through both stages: the input stage accepts when it is empty or when it is advancing into the output stage.
  - Throughput stays 1 per cycle; the unit can hold up to 2 results in flight.
  - Reset clears both stages.
- Undefined: single-stage behaviour as above, latency 1.
- Ports are identical in both builds.

Test Plan:
- NOT sweep, WIDTH=32, out_ready=1: a = 0, 10, 32, 33 on consecutive cycles, op=0.
  - Required results one cycle later: FFFFFFFF, FFFFFFF5, FFFFFFDF, FFFFFFDE; zero=0 each.
  - ops_done=4.
- All ops: a=F0F0F0F0, b=FF00FF00, op 0..7.
  - Required results: 0F0F0F0F, F000F000, FFF0FFF0, 0FF00FF0, 0FFF0FFF, 000F000F, F00FF00F, F0F0F0F0.
- Zero flag: op=1, a=AAAAAAAA, b=55555555 -> result=0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after one accept.
  - Required: in_ready=0 and result stable throughout.
  - Raise out_ready with a new in_valid: both transfers occur in the same cycle, out_valid stays 1, ops_done increments once.
- Reset mid-stall: assert rst asynchronously (between clock edges) while out_valid=1 and stalled.
  - Required immediately: out_valid=0, result=0, zero=1, ops_done=0.
  - After release: the next accept completes normally.
- Saturation: CNT_W=3, drive 10 back-to-back transfers -> ops_done holds at 7.
- With LU_INPUT_STAGE_EN: repeat the NOT sweep; results appear 2 cycles after accept, same values.
